// File: rtl/vscale_dm_hart_ctrl_pkg.sv
// Shared opcodes, response codes and FSM encoding for the debug-module hart controller.
// Optional timeout support is enabled with the VSCALE_DM_TIMEOUT_EN macro (see top).
package vscale_dm_hart_ctrl_pkg;

    localparam int DM_OP_W  = 2;
    localparam int DM_ERR_W = 2;

    typedef enum logic [DM_OP_W-1:0] {
        DM_OP_HALT      = 2'd0,
        DM_OP_RESUME    = 2'd1,
        DM_OP_READ_REG  = 2'd2,
        DM_OP_WRITE_REG = 2'd3
    } dm_op_e;

    typedef enum logic [DM_ERR_W-1:0] {
        DM_ERR_OK         = 2'd0,
        DM_ERR_NOT_HALTED = 2'd1,
        DM_ERR_TIMEOUT    = 2'd2,
        DM_ERR_RSVD       = 2'd3
    } dm_err_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HALT_WAIT   = 3'd1,
        ST_RESUME_WAIT = 3'd2,
        ST_RD_WAIT     = 3'd3,
        ST_WR_WAIT     = 3'd4,
        ST_RESP        = 3'd5
    } dm_state_e;

endpackage

// File: rtl/vscale_dm_timeout_ctr.sv
// Wait-state cycle counter: held at zero while cleared, counts while enabled,
// flags expiry on the TIMEOUT_CYCLES-th cycle of a wait.
module vscale_dm_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expired = i_enable && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vscale_dm_hart_ctrl.sv
// Debug-module initiator for the core hart debug ports: one abstract command at a time,
// owns the halted status. Define VSCALE_DM_TIMEOUT_EN to abort unacknowledged requests.
module vscale_dm_hart_ctrl
    import vscale_dm_hart_ctrl_pkg::*;
#(
    parameter int XPR_LEN        = 32,
    parameter int REGNO_WIDTH    = 13,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [REGNO_WIDTH-1:0] cmd_regno,
    input  logic [XPR_LEN-1:0]     cmd_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_err,
    output logic [XPR_LEN-1:0]     resp_rdata,
    output logic                   halted,
    output logic                   haltreq,
    input  logic                   haltack,
    output logic                   resumereq,
    input  logic                   resumeack,
    output logic [REGNO_WIDTH-1:0] register_index,
    output logic                   debug_read,
    output logic                   debug_write,
    output logic [XPR_LEN-1:0]     debug_wdata,
    input  logic [XPR_LEN-1:0]     debug_rdata,
    input  logic                   reg_rack,
    input  logic                   reg_wack
);

    dm_state_e              r_state, w_state_next;
    logic                   r_halted, w_halted_next;
    logic [REGNO_WIDTH-1:0] r_regno, w_regno_next;
    logic [XPR_LEN-1:0]     r_wdata, w_wdata_next;
    dm_err_e                r_err, w_err_next;
    logic [XPR_LEN-1:0]     r_rdata, w_rdata_next;
    logic                   w_expired;

`ifdef VSCALE_DM_TIMEOUT_EN
    logic w_in_wait;
    assign w_in_wait = (r_state == ST_HALT_WAIT) || (r_state == ST_RESUME_WAIT) ||
                       (r_state == ST_RD_WAIT)   || (r_state == ST_WR_WAIT);

    vscale_dm_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );
`else
    // No timeout: waits are unbounded. TIMEOUT_CYCLES is referenced only so both builds share one interface.
    assign w_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Every core-facing request is a pure decode of registered state, so acks never feed through.
    assign cmd_ready      = (r_state == ST_IDLE) && !reset;
    assign resp_valid     = (r_state == ST_RESP);
    assign resp_err       = r_err;
    assign resp_rdata     = r_rdata;
    assign halted         = r_halted;
    assign haltreq        = (r_state == ST_HALT_WAIT);
    assign resumereq      = (r_state == ST_RESUME_WAIT);
    assign debug_read     = (r_state == ST_RD_WAIT);
    assign debug_write    = (r_state == ST_WR_WAIT);
    assign register_index = (debug_read || debug_write) ? r_regno : '0;
    assign debug_wdata    = debug_write ? r_wdata : '0;

    always_comb begin
        w_state_next  = r_state;
        w_halted_next = r_halted;
        w_regno_next  = r_regno;
        w_wdata_next  = r_wdata;
        w_err_next    = r_err;
        w_rdata_next  = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_regno_next = cmd_regno;
                    w_wdata_next = cmd_wdata;
                    w_err_next   = DM_ERR_OK;
                    case (cmd_op)
                        DM_OP_HALT:   w_state_next = r_halted ? ST_RESP : ST_HALT_WAIT;
                        DM_OP_RESUME: w_state_next = r_halted ? ST_RESUME_WAIT : ST_RESP;
                        DM_OP_READ_REG: begin
                            w_state_next = r_halted ? ST_RD_WAIT : ST_RESP;
                            if (!r_halted) w_err_next = DM_ERR_NOT_HALTED;
                        end
                        default: begin
                            w_state_next = r_halted ? ST_WR_WAIT : ST_RESP;
                            if (!r_halted) w_err_next = DM_ERR_NOT_HALTED;
                        end
                    endcase
                end
            end
            ST_HALT_WAIT: begin
                if (haltack) begin
                    w_halted_next = 1'b1;
                    w_state_next  = ST_RESP;
                end else if (w_expired) begin
                    w_err_next   = DM_ERR_TIMEOUT;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESUME_WAIT: begin
                if (resumeack) begin
                    w_halted_next = 1'b0;
                    w_state_next  = ST_RESP;
                end else if (w_expired) begin
                    w_err_next   = DM_ERR_TIMEOUT;
                    w_state_next = ST_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (reg_rack) begin
                    w_rdata_next = debug_rdata;
                    w_state_next = ST_RESP;
                end else if (w_expired) begin
                    w_err_next   = DM_ERR_TIMEOUT;
                    w_state_next = ST_RESP;
                end
            end
            ST_WR_WAIT: begin
                if (reg_wack) begin
                    w_state_next = ST_RESP;
                end else if (w_expired) begin
                    w_err_next   = DM_ERR_TIMEOUT;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_rdata_next = '0;
                    w_err_next   = DM_ERR_OK;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
            r_regno  <= '0;
            r_wdata  <= '0;
            r_err    <= DM_ERR_OK;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_halted <= w_halted_next;
            r_regno  <= w_regno_next;
            r_wdata  <= w_wdata_next;
            r_err    <= w_err_next;
            r_rdata  <= w_rdata_next;
        end
    end

endmodule

// File: doc/vscale_dm_hart_ctrl.md
Name: vscale_dm_hart_ctrl

Overview:
- Debug-module-side initiator for the core's debug-spec-0.13 hart interface. It drives haltreq/resumereq and register-access requests toward the core and consumes haltack/resumeack/reg_rack/reg_wack.
- Accepts one abstract command at a time from the debug transport (DMI/JTAG front end) over a valid/ready channel. Sequences the core handshake and returns one response per command.
- Sits between the transport and the core's debug ports. It owns the authoritative halted status.

Parameters:
- XPR_LEN, 32, register data width (matches core `XPR_LEN)
- REGNO_WIDTH, 13, register index width
- TIMEOUT_CYCLES, 1024, cycles to wait for a core ack before aborting (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid and cmd_ready are both high
- cmd_op  in  2  0=HALT, 1=RESUME, 2=READ_REG, 3=WRITE_REG
- cmd_regno  in  REGNO_WIDTH  register index for READ_REG/WRITE_REG
- cmd_wdata  in  XPR_LEN  write data for WRITE_REG
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_err  out  2  0=OK, 1=NOT_HALTED, 2=TIMEOUT, 3=reserved
- resp_rdata  out  XPR_LEN  read data; 0 unless READ_REG returns OK
- halted  out  1  hart halted status
- haltreq  out  1  to core
- haltack  in  1  from core
- resumereq  out  1  to core
- resumeack  in  1  from core
- register_index  out  REGNO_WIDTH  to core
- debug_read  out  1  to core
- debug_write  out  1  to core
- debug_wdata  out  XPR_LEN  to core
- debug_rdata  in  XPR_LEN  from core
- reg_rack  in  1  read ack from core
- reg_wack  in  1  write ack from core

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0, halted=0, state IDLE. Reset mid-operation aborts at the next edge; any pending request is dropped with no response.
- States: IDLE, HALT_WAIT, RESUME_WAIT, RD_WAIT, WR_WAIT, RESP.
- IDLE:
  - cmd_ready=1 only in IDLE. On accept, cmd_op, cmd_regno and cmd_wdata are registered.
  - HALT while halted=1 -> RESP with OK. No haltreq pulse.
  - HALT while running -> HALT_WAIT.
  - RESUME while halted=0 -> RESP with OK.
  - RESUME while halted -> RESUME_WAIT.
  - READ_REG/WRITE_REG while halted=0 -> RESP with NOT_HALTED. The core sees no request.
  - READ_REG while halted -> RD_WAIT; WRITE_REG while halted -> WR_WAIT.
- HALT_WAIT: haltreq=1, held. At the first edge where haltack=1: haltreq drops, halted<=1, go to RESP with OK.
- RESUME_WAIT: resumereq=1, held. At the first edge where resumeack=1: resumereq drops, halted<=0, go to RESP with OK.
- RD_WAIT: register_index=regno and debug_read=1, held. At the first edge where reg_rack=1, debug_rdata is captured into resp_rdata, then go to RESP with OK.
- WR_WAIT: register_index=regno, debug_wdata=wdata and debug_write=1, held. At the first edge where reg_wack=1, go to RESP with OK.
- RESP: resp_valid=1 with stable resp_err and resp_rdata until resp_ready. On the handshake edge return to IDLE. resp_rdata clears to 0 on leaving RESP.
- Latency:
  - Minimum command-accept to resp_valid is 2 cycles: accept edge, then the ack seen at the next edge.
  - An immediate response (no core access) is visible 1 cycle after accept.
- Exclusivity: at most one of haltreq/resumereq/debug_read/debug_write is high at any time.
- Request outputs are registered; the core never sees a combinational dependence on ack inputs.
- Stray acks: acks arriving in IDLE, RESP, or for the wrong request are ignored.
- Simultaneous events: cmd_valid arriving while in RESP is not accepted until the cycle after the response handshake.

Optional Feature:
- Macro: VSCALE_DM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to each *_WAIT state and increments every cycle in it.
  - When the count reaches TIMEOUT_CYCLES-1 without ack, the request drops and the block goes to RESP with TIMEOUT. halted is unchanged.
  - An ack arriving on the same edge as the timeout wins and yields OK.
- Undefined: no counter; *_WAIT states wait indefinitely.

Decomposition:
- Shared package/header (vscale_dm_constants.vh): DM_OP_* opcode constants, DM_ERR_* codes, state encodings, op/err widths.
- Optional sub-module: vscale_dm_timeout_ctr (clear/enable/expired), instantiated only under VSCALE_DM_TIMEOUT_EN.
- Everything else stays flat.

Test Plan:
- Halt: HALT cmd, core raises haltack 3 cycles after haltreq -> haltreq high exactly until the ack edge; halted=1; resp OK.
- Halted write then read:
  - WRITE_REG regno=0x1001 wdata=0xDEADBEEF, reg_wack after 2 cycles -> debug_write/register_index/debug_wdata held until the ack; resp OK.
  - Then READ_REG 0x1001 with debug_rdata=0xDEADBEEF on reg_rack -> resp_rdata=0xDEADBEEF.
- Access while running: READ_REG with halted=0 -> debug_read never asserts; resp_err=1 one cycle after accept.
- Resume and redundant commands:
  - RESUME while halted -> resumereq held until resumeack; halted=0; resp OK.
  - Second RESUME -> immediate OK, no resumereq.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp fields stable; cmd_ready=0 throughout.
- Timeout/reset (VSCALE_DM_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - HALT with no ack -> haltreq drops after 8 cycles; resp_err=2; halted=0.
  - Separately, reset asserted mid-RD_WAIT -> debug_read=0 next cycle; no response.
